prog_sequencer: RTL

//  Run-control FSM that sequences the program counter through the test bench's Start/Done protocol.

---
 rtl/prog_sequencer_if.sv | 31 +++
 rtl/prog_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - run-control bundle between bench/decoder and the PC sequencer
interface prog_sequencer_if #(
   parameter int A         = 10,
   parameter int NUM_PROGS = 3,
   parameter int CYC_W     = 16
);
   localparam int PW = $clog2(NUM_PROGS + 1);

   logic          start;
   logic          halt;
   logic          branch_rel_en;
   logic          alu_flag;
   logic [A-1:0]  target;
   logic          pc_hold;
   logic          pc_load_en;
   logic [A-1:0]  pc_load_val;
   logic          done;
   logic          all_done;
   logic [PW-1:0] prog_idx;
   logic [CYC_W-1:0] cycle_count;

   modport master (
      output start, halt, branch_rel_en, alu_flag, target,
      input  pc_hold, pc_load_en, pc_load_val, done, all_done, prog_idx, cycle_count
   );

   modport slave (
      input  start, halt, branch_rel_en, alu_flag, target,
      output pc_hold, pc_load_en, pc_load_val, done, all_done, prog_idx, cycle_count
   );
endinterface

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launches programs on Start falling edge, relocates branches, freezes PC on halt
module prog_sequencer #(
   parameter int A         = 10,
   parameter int NUM_PROGS = 3,
   parameter int BASE0     = 0,
   parameter int BASE1     = 200,
   parameter int BASE2     = 500,
   parameter int CYC_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   prog_sequencer_if.slave  io_bus
);
   localparam int PW = $clog2(NUM_PROGS + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN, ST_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_start;
   logic             r_done;
   logic             r_all_done;
   logic [PW-1:0]    r_prog_idx;
   logic [CYC_W-1:0] r_cycle_count;

   logic             w_rise;
   logic             w_fall;
   logic             w_launch;
   logic             w_halt;
   logic             w_rearm;
   logic             w_pc_hold;
   logic             w_pc_load_en;
   logic [A-1:0]     w_pc_load_val;

   function automatic logic [A-1:0] base_of(input logic [PW-1:0] idx);
      if (idx == PW'(0))
         return A'(BASE0);
      else if (idx == PW'(1))
         return A'(BASE1);
      else
         return A'(BASE2);
   endfunction

   assign w_rise = !r_start && io_bus.start;
   assign w_fall = r_start && !io_bus.start;

   // Reset forces the PC to hold with no load, regardless of state.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_hold     = 1'b1;
      w_pc_load_en  = 1'b0;
      w_pc_load_val = '0;
      w_launch      = 1'b0;
      w_halt        = 1'b0;
      w_rearm       = 1'b0;
      if (!i_reset) begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise)
                  w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
               if (w_fall) begin
                  w_launch      = 1'b1;
                  w_pc_hold     = 1'b0;
                  w_pc_load_en  = 1'b1;
                  w_pc_load_val = base_of(r_prog_idx);
                  w_state_nxt   = ST_RUN;
               end
            end
            ST_RUN: begin
               w_pc_hold = 1'b0;
               if (io_bus.halt) begin
                  w_pc_hold   = 1'b1;
                  w_halt      = 1'b1;
                  w_state_nxt = ST_DONE;
               end else if (io_bus.branch_rel_en && io_bus.alu_flag) begin
                  // prog_idx already counts the running program, so its base is idx-1
                  w_pc_load_en  = 1'b1;
                  w_pc_load_val = base_of(r_prog_idx - PW'(1)) + io_bus.target;
               end
            end
            ST_DONE: begin
               if (w_rise && !r_all_done) begin
                  w_rearm     = 1'b1;
                  w_state_nxt = ST_ARMED;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_start       <= 1'b0;
         r_done        <= 1'b0;
         r_all_done    <= 1'b0;
         r_prog_idx    <= '0;
         r_cycle_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_start <= io_bus.start;
         if (w_launch) begin
            r_prog_idx    <= r_prog_idx + PW'(1);
            r_cycle_count <= '0;
         end else if (r_state == ST_RUN && r_cycle_count != '1) begin
            r_cycle_count <= r_cycle_count + CYC_W'(1);
         end
         if (w_halt) begin
            r_done <= 1'b1;
            if (r_prog_idx == PW'(NUM_PROGS))
               r_all_done <= 1'b1;
         end
         if (w_rearm)
            r_done <= 1'b0;
      end
   end

   assign io_bus.pc_hold     = w_pc_hold;
   assign io_bus.pc_load_en  = w_pc_load_en;
   assign io_bus.pc_load_val = w_pc_load_val;
   assign io_bus.done        = r_done;
   assign io_bus.all_done    = r_all_done;
   assign io_bus.prog_idx    = r_prog_idx;
   assign io_bus.cycle_count = r_cycle_count;
endmodule
